// File: rtl/iomem_pkg.sv
// Shared types and defaults for the picosoc iomem router.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } iomem_state_e;

  localparam logic [7:0] SEL_LED   = 8'h03;
  localparam logic [7:0] SEL_AUDIO = 8'h04;
  localparam logic [7:0] SEL_VIDEO = 8'h05;
  localparam logic [7:0] SEL_SLOT3 = 8'h06;

  localparam logic [31:0] SLOT_SEL_DEF = {SEL_SLOT3, SEL_VIDEO, SEL_AUDIO, SEL_LED};
  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/iomem_addr_decode.sv
// Priority slot decoder: lowest-index slot whose selector matches wins.
module iomem_addr_decode #(
  parameter int NUM_SLOTS = 4,
  parameter int SEL_W     = 8,
  parameter int IDX_W     = 2,
  parameter logic [SEL_W*NUM_SLOTS-1:0] SLOT_SEL = '0
) (
  input  logic [SEL_W-1:0]     i_sel,
  output logic                 o_hit,
  output logic [IDX_W-1:0]     o_idx,
  output logic [NUM_SLOTS-1:0] o_onehot
);

  // Scan downwards so the lowest matching index is written last.
  always_comb begin
    o_hit    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (i_sel == SLOT_SEL[SEL_W*i +: SEL_W]) begin
        o_hit       = 1'b1;
        o_idx       = IDX_W'(i);
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iomem_router.sv
// iomem interconnect: registered slot selects, ready handshake, read return,
// and unmapped/timeout error response with error capture.
module iomem_router
  import iomem_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_W    = 32,
  parameter int SEL_HI    = 31,
  parameter int SEL_LO    = 24,
  parameter logic [(SEL_HI-SEL_LO+1)*NUM_SLOTS-1:0] SLOT_SEL = SLOT_SEL_DEF,
  parameter int TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_m_valid,
  input  logic [DATA_W/8-1:0]         i_m_wstrb,
  input  logic [31:0]                 i_m_addr,
  input  logic [DATA_W-1:0]           i_m_wdata,
  output logic                        o_m_ready,
  output logic [DATA_W-1:0]           o_m_rdata,
  output logic [NUM_SLOTS-1:0]        o_s_valid,
  output logic [DATA_W/8-1:0]         o_s_wstrb,
  output logic [31:0]                 o_s_addr,
  output logic [DATA_W-1:0]           o_s_wdata,
  input  logic [NUM_SLOTS-1:0]        i_s_ready,
  input  logic [NUM_SLOTS*DATA_W-1:0] i_s_rdata,
  output logic                        o_err_pulse,
  output logic [31:0]                 o_err_addr,
  output logic [7:0]                  o_err_count
);

  localparam int SEL_W = SEL_HI - SEL_LO + 1;
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  iomem_state_e r_state, w_state_nxt;

  logic                 w_hit;
  logic [IDX_W-1:0]     w_idx;
  logic [NUM_SLOTS-1:0] w_onehot;
  logic                 w_sel_ready;
  logic [DATA_W-1:0]    w_sel_rdata;
  logic                 w_accept, w_unmapped, w_done, w_tmo, w_err;

  logic [IDX_W-1:0]     r_slot;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_m_ready, r_err_pulse;
  logic [DATA_W-1:0]    r_m_rdata, r_s_wdata;
  logic [NUM_SLOTS-1:0] r_s_valid;
  logic [DATA_W/8-1:0]  r_s_wstrb;
  logic [31:0]          r_s_addr, r_err_addr;
  logic [7:0]           r_err_count;

  iomem_addr_decode #(
    .NUM_SLOTS (NUM_SLOTS),
    .SEL_W     (SEL_W),
    .IDX_W     (IDX_W),
    .SLOT_SEL  (SLOT_SEL)
  ) u_decode (
    .i_sel    (i_m_addr[SEL_HI:SEL_LO]),
    .o_hit    (w_hit),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  assign w_sel_ready = i_s_ready[r_slot];
  assign w_sel_rdata = i_s_rdata[DATA_W*r_slot +: DATA_W];

  // Ready wins over a coinciding timeout because it is tested first.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_unmapped  = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_m_valid) begin
          if (w_hit) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_ACCESS;
          end else begin
            w_unmapped  = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        if (w_sel_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_err = w_unmapped | w_tmo;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_slot      <= '0;
      r_cnt       <= '0;
      r_m_ready   <= 1'b0;
      r_err_pulse <= 1'b0;
      r_m_rdata   <= '0;
      r_s_valid   <= '0;
      r_s_wstrb   <= '0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_err_addr  <= '0;
      r_err_count <= '0;
    end else begin
      r_m_ready   <= w_done | w_err;
      r_err_pulse <= w_err;
      if (w_accept) begin
        r_slot    <= w_idx;
        r_s_valid <= w_onehot;
        r_s_wstrb <= i_m_wstrb;
        r_s_addr  <= i_m_addr;
        r_s_wdata <= i_m_wdata;
        r_cnt     <= '0;
      end else if (w_done || w_tmo) begin
        r_s_valid <= '0;
      end else if (r_state == ST_ACCESS) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done)     r_m_rdata <= w_sel_rdata;
      else if (w_err) r_m_rdata <= ERR_DATA;
      if (w_err) begin
        r_err_addr <= w_unmapped ? i_m_addr : r_s_addr;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign o_m_ready   = r_m_ready;
  assign o_m_rdata   = r_m_rdata;
  assign o_s_valid   = r_s_valid;
  assign o_s_wstrb   = r_s_wstrb;
  assign o_s_addr    = r_s_addr;
  assign o_s_wdata   = r_s_wdata;
  assign o_err_pulse = r_err_pulse;
  assign o_err_addr  = r_err_addr;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_iomem_router.sv
// Table-driven bench for iomem_router with a response scoreboard.
module tb_iomem_router;

  localparam int TMO = 8;
  // Slot 3 duplicates slot 1's selector so the priority rule can be observed.
  localparam logic [31:0] SEL  = {8'h04, 8'h05, 8'h04, 8'h03};
  localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_valid;
  logic [3:0]   m_wstrb;
  logic [31:0]  m_addr, m_wdata;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid, s_wstrb;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_ready = 4'b0;
  logic [127:0] s_rdata;
  logic         err_pulse;
  logic [31:0]  err_addr;
  logic [7:0]   err_count;

  always #5 clk = ~clk;

  iomem_router #(
    .NUM_SLOTS (4),
    .DATA_W    (32),
    .SEL_HI    (31),
    .SEL_LO    (24),
    .SLOT_SEL  (SEL),
    .TIMEOUT   (TMO),
    .ERR_DATA  (ERRD)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_m_valid   (m_valid),
    .i_m_wstrb   (m_wstrb),
    .i_m_addr    (m_addr),
    .i_m_wdata   (m_wdata),
    .o_m_ready   (m_ready),
    .o_m_rdata   (m_rdata),
    .o_s_valid   (s_valid),
    .o_s_wstrb   (s_wstrb),
    .o_s_addr    (s_addr),
    .o_s_wdata   (s_wdata),
    .i_s_ready   (s_ready),
    .i_s_rdata   (s_rdata),
    .o_err_pulse (err_pulse),
    .o_err_addr  (err_addr),
    .o_err_count (err_count)
  );

  assign s_rdata = {32'hDDDD_3333, 32'hCCCC_2222, 32'h1234_5678, 32'hAAAA_0000};

  // Slave model: the selected slot raises ready after sl_waits cycles of s_valid.
  int         sl_waits = 0;
  logic       sl_en    = 1'b1;
  logic [3:0] sl_noise = 4'b0;
  int         vcnt     = 0;

  always begin
    @(posedge clk);
    #1;
    if (s_valid != 4'b0) begin
      s_ready = ((sl_en && vcnt >= sl_waits) ? s_valid : 4'b0) | (sl_noise & ~s_valid);
      vcnt++;
    end else begin
      vcnt    = 0;
      s_ready = sl_noise;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          waits;
    logic        rdy_en;
    logic [3:0]  noise;
    logic        drop;
    logic [3:0]  exp_sv;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_vc;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  mdl_errcnt = 8'd0;
  logic [31:0] mdl_erraddr = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v, input string nm);
    exp_t e, got;
    int   lat, vc;
    bit   seen, bus_ok;
    sl_waits = v.waits;
    sl_en    = v.rdy_en;
    sl_noise = v.noise;
    @(posedge clk);
    #1;
    m_addr  = v.addr;
    m_wstrb = v.wstrb;
    m_wdata = v.wdata;
    m_valid = 1'b1;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.addr  = v.addr;
    sb.push_back(e);
    lat = 0; vc = 0; seen = 0; bus_ok = 1;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      if (v.drop) begin
        #1;
        m_valid = 1'b0;
      end
      @(negedge clk);
      if (s_valid != 4'b0) begin
        if (s_valid == v.exp_sv && s_addr == v.addr && s_wdata == v.wdata && s_wstrb == v.wstrb)
          vc++;
        else
          bus_ok = 0;
      end
      if (m_ready) begin
        seen = 1;
        got  = sb.pop_front();
        if (got.err) begin
          mdl_erraddr = got.addr;
          if (mdl_errcnt != 8'hFF) mdl_errcnt++;
        end
        chk({nm, "_latency"}, lat, v.exp_lat);
        chk({nm, "_rdata"}, m_rdata, got.rdata);
        chk({nm, "_err_pulse"}, err_pulse, got.err);
        chk({nm, "_err_addr"}, err_addr, mdl_erraddr);
        chk({nm, "_err_count"}, err_count, mdl_errcnt);
        chk({nm, "_sv_at_ready"}, s_valid, 4'b0);
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_no_ready: got no m_ready within %0d cycles, required one", nm, lat);
      sb.delete();
    end
    chk({nm, "_valid_cycles"}, vc, v.exp_vc);
    chk({nm, "_bus_ok"}, bus_ok, 1'b1);
    @(posedge clk);
    #1;
    m_valid  = 1'b0;
    sl_noise = 4'b0;
  endtask

  initial begin
    bit rdy_seen;
    //          addr          wstrb wdata         wt en   noise    drop  sv       rdata          err  lat vc
    vecs[0] = '{32'h0400_0010, 4'h0, 32'h0,        0, 1'b1, 4'b0000, 1'b0, 4'b0010, 32'h1234_5678, 1'b0, 2, 1};
    vecs[1] = '{32'h0300_0000, 4'hF, 32'hA5,       3, 1'b1, 4'b0000, 1'b0, 4'b0001, 32'hAAAA_0000, 1'b0, 5, 4};
    vecs[2] = '{32'h0900_0000, 4'h0, 32'h0,        0, 1'b1, 4'b0000, 1'b0, 4'b0000, ERRD,          1'b1, 1, 0};
    vecs[3] = '{32'h0500_0000, 4'h0, 32'h0,        0, 1'b0, 4'b0000, 1'b0, 4'b0100, ERRD,          1'b1, 9, 8};
    vecs[4] = '{32'h0500_0004, 4'h0, 32'h0,        7, 1'b1, 4'b0000, 1'b0, 4'b0100, 32'hCCCC_2222, 1'b0, 9, 8};
    vecs[5] = '{32'h04FF_FFFC, 4'h0, 32'h0,        1, 1'b1, 4'b1101, 1'b0, 4'b0010, 32'h1234_5678, 1'b0, 3, 2};
    vecs[6] = '{32'h0300_0008, 4'h3, 32'h0000_BEEF, 2, 1'b1, 4'b0000, 1'b1, 4'b0001, 32'hAAAA_0000, 1'b0, 4, 3};

    rst = 1'b1; m_valid = 1'b0; m_wstrb = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_m_ready", m_ready, 1'b0);
    chk("rst_s_valid", s_valid, 4'b0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_access(vecs[i], $sformatf("vec%0d", i));
    chk("hold_s_wdata", s_wdata, vecs[6].wdata);
    chk("hold_s_wstrb", s_wstrb, vecs[6].wstrb);

    // Reset in the middle of a slot-1 access that the slave never completes.
    sl_waits = 0; sl_en = 1'b0; sl_noise = 4'b0;
    @(posedge clk);
    #1;
    m_addr = 32'h0400_0000; m_wstrb = 4'h0; m_wdata = 32'h0; m_valid = 1'b1;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pre_sv", s_valid, 4'b0010);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_async_sv", s_valid, 4'b0);
    rdy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_ready) rdy_seen = 1;
    end
    chk("midrst_no_ready", rdy_seen, 1'b0);
    rst = 1'b0;
    mdl_errcnt = 8'd0;
    mdl_erraddr = 32'd0;
    chk("midrst_err_count", err_count, 8'd0);
    do_access(vecs[0], "post_rst");

    for (int i = 0; i < 260; i++) do_access(vecs[2], "sat");
    chk("err_count_saturated", err_count, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
